srrc_sym_fir_param: RTL and testbench



---
 rtl/srrc_sym_fir_param_if.sv | 26 ++
 rtl/srrc_sym_fir_param.sv | 165 ++++++++++++++++
 tb/tb_srrc_sym_fir_param.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/srrc_sym_fir_param_if.sv
// Sample stream and coefficient-load bus for srrc_sym_fir_param.
// The master drives samples and coefficient writes; the filter (slave) returns out/out_valid.
interface srrc_sym_fir_param_if #(
  parameter int DATA_W = 18,
  parameter int COEF_W = 18,
  parameter int AW     = 7
);
  logic                     sam_clk_en;
  logic signed [DATA_W-1:0] in;
  logic signed [DATA_W-1:0] out;
  logic                     out_valid;
  logic                     coef_we;
  logic        [AW-1:0]     coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     coef_swap;

  modport master (
    output sam_clk_en, in, coef_we, coef_addr, coef_wdata, coef_swap,
    input  out, out_valid
  );

  modport slave (
    input  sam_clk_en, in, coef_we, coef_addr, coef_wdata, coef_swap,
    output out, out_valid
  );
endinterface

// File: rtl/srrc_sym_fir_param.sv
// Parametrised pipelined even-symmetric FIR with double-buffered coefficients.
// Optional macro SRRC_FIR_SAT_EN: saturate the output instead of wrapping.
module srrc_sym_fir_param #(
  parameter int DATA_W    = 18,
  parameter int COEF_W    = 18,
  parameter int NTAPS     = 189,
  parameter int OUT_SHIFT = 17
) (
  input logic                  clk,
  input logic                  reset,
  srrc_sym_fir_param_if.slave  s_bus
);

  function automatic int clog4(input int n);
    int d;
    int cap;
    d   = 0;
    cap = 1;
    while (cap < n) begin
      cap = cap * 4;
      d   = d + 1;
    end
    return d;
  endfunction

  localparam int H   = (NTAPS + 1) / 2;
  localparam int D   = clog4(H);
  localparam int LAT = 4 + D;
  localparam int PW  = DATA_W + 1 + COEF_W;
  localparam int SW  = PW + 2 * D;
  localparam logic signed [SW:0] RND = (SW+1)'(1) <<< (OUT_SHIFT - 1);

  function automatic int nodes(input int lvl);
    int n;
    n = H;
    for (int i = 0; i < lvl; i++) n = (n + 3) / 4;
    return n;
  endfunction

  function automatic logic signed [SW:0] round_shift(input logic signed [SW-1:0] v);
    logic signed [SW:0] t;
    t = (SW+1)'(v) + RND;
    return t >>> OUT_SHIFT;
  endfunction

  function automatic logic signed [DATA_W-1:0] reduce(input logic signed [SW:0] v);
`ifdef SRRC_FIR_SAT_EN
    if ((&v[SW:DATA_W-1]) || (~|v[SW:DATA_W-1])) return v[DATA_W-1:0];
    else if (v[SW])                               return {1'b1, {(DATA_W-1){1'b0}}};
    else                                          return {1'b0, {(DATA_W-1){1'b1}}};
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  logic signed [DATA_W-1:0] r_x       [NTAPS];
  logic signed [COEF_W-1:0] r_shadow  [H];
  logic signed [COEF_W-1:0] r_active  [H];
  logic signed [DATA_W:0]   r_pre_p0  [H];
  logic signed [PW-1:0]     r_prod_p1 [H];
  logic signed [SW-1:0]     w_tree;
  logic signed [DATA_W-1:0] r_rnd;
  logic signed [DATA_W-1:0] r_out;
  logic        [LAT-1:0]    r_vld;
  logic                     r_out_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) r_x[i] <= '0;
    end else if (s_bus.sam_clk_en) begin
      r_x[0] <= s_bus.in;
      for (int i = 1; i < NTAPS; i++) r_x[i] <= r_x[i-1];
    end
  end

  // Swap copies the pre-write shadow since both updates are non-blocking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < H; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      if (s_bus.coef_we && (int'(s_bus.coef_addr) < H))
        r_shadow[s_bus.coef_addr] <= s_bus.coef_wdata;
      if (s_bus.coef_swap)
        r_active <= r_shadow;
    end
  end

  // Stage P: fold symmetric taps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < H; k++) r_pre_p0[k] <= '0;
    end else begin
      for (int k = 0; k < H - 1; k++)
        r_pre_p0[k] <= (DATA_W+1)'(r_x[k]) + (DATA_W+1)'(r_x[NTAPS-1-k]);
      r_pre_p0[H-1] <= (DATA_W+1)'(r_x[H-1]);
    end
  end

  // Stage M: full-precision products against the active bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < H; k++) r_prod_p1[k] <= '0;
    end else begin
      for (int k = 0; k < H; k++)
        r_prod_p1[k] <= PW'(r_pre_p0[k]) * PW'(r_active[k]);
    end
  end

  // Stages T1..TD: radix-4 tree, each level two bits wider than its inputs
  genvar gl;
  for (gl = 1; gl <= D; gl++) begin : g_lvl
    localparam int NI = nodes(gl - 1);
    localparam int NO = nodes(gl);
    localparam int WI = PW + 2 * (gl - 1);
    localparam int WO = PW + 2 * gl;

    logic signed [WI-1:0] w_src  [NI];
    logic signed [WO-1:0] w_leaf [4*NO];
    logic signed [WO-1:0] r_sum  [NO];

    if (gl == 1) begin : g_src
      assign w_src = r_prod_p1;
    end else begin : g_src
      assign w_src = g_lvl[gl-1].r_sum;
    end

    always_comb begin
      for (int i = 0; i < 4 * NO; i++) w_leaf[i] = '0;
      for (int i = 0; i < NI; i++)     w_leaf[i] = WO'(w_src[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int j = 0; j < NO; j++) r_sum[j] <= '0;
      end else begin
        for (int j = 0; j < NO; j++)
          r_sum[j] <= w_leaf[4*j] + w_leaf[4*j+1] + w_leaf[4*j+2] + w_leaf[4*j+3];
      end
    end
  end

  assign w_tree = g_lvl[D].r_sum[0];

  // Stage R and stage O; valid travels one bit per stage alongside the data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rnd       <= '0;
      r_out       <= '0;
      r_vld       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_rnd       <= reduce(round_shift(w_tree));
      r_vld       <= {r_vld[LAT-2:0], s_bus.sam_clk_en};
      r_out_valid <= r_vld[LAT-1];
      if (r_vld[LAT-1]) r_out <= r_rnd;
    end
  end

  assign s_bus.out       = r_out;
  assign s_bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_srrc_sym_fir_param.sv
// Directed bench for srrc_sym_fir_param at default parameters (189 taps, latency 8).
module tb_srrc_sym_fir_param;

  localparam int LAT = 8;
  localparam int NS  = 195;

`ifdef SRRC_FIR_SAT_EN
  localparam longint SAT_EXP = 131071;
`else
  localparam longint SAT_EXP = 130694;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

  srrc_sym_fir_param_if #(.DATA_W(18), .COEF_W(18), .AW(7)) bus_if ();

  srrc_sym_fir_param dut (
    .clk   (clk),
    .reset (reset),
    .s_bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_shadow(input int base, input int step);
    for (int k = 0; k < 95; k++) begin
      bus_if.coef_we    = 1'b1;
      bus_if.coef_addr  = 7'(k);
      bus_if.coef_wdata = 18'(base + step * k);
      tick();
    end
    bus_if.coef_we = 1'b0;
  endtask

  task automatic pulse_swap();
    bus_if.coef_swap = 1'b1;
    tick();
    bus_if.coef_swap = 1'b0;
  endtask

  function automatic longint imp_exp(input int n);
    int k;
    if (n > 188) return 0;
    k = (n < 188 - n) ? n : 188 - n;
    return 1000 + 10 * k;
  endfunction

  task automatic impulse_run(input string tag);
    longint got[$];
    int     first;
    first = -1;
    for (int cyc = 0; cyc < NS * 4 + 12; cyc++) begin
      bus_if.sam_clk_en = ((cyc % 4) == 0) && (cyc < NS * 4);
      bus_if.in         = (cyc == 0) ? 18'sd65536 : 18'sd0;
      tick();
      if (bus_if.out_valid) begin
        if (first < 0) first = cyc;
        got.push_back(longint'(bus_if.out));
      end
    end
    bus_if.sam_clk_en = 1'b0;
    check($sformatf("%s_latency", tag), first, LAT);
    check($sformatf("%s_count", tag), got.size(), NS);
    for (int n = 0; n < NS && n < got.size(); n++)
      check($sformatf("%s_out%0d", tag, n), got[n], imp_exp(n));
  endtask

  initial begin
    int nv;
    int old;
    total = 0;
    bad   = 0;
    bus_if.sam_clk_en = 1'b0;
    bus_if.in         = '0;
    bus_if.coef_we    = 1'b0;
    bus_if.coef_addr  = '0;
    bus_if.coef_wdata = '0;
    bus_if.coef_swap  = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    check("reset_out", longint'(bus_if.out), 0);
    check("reset_valid", longint'(bus_if.out_valid), 0);
    reset = 1'b0;
    tick();

    // Impulse response with a ramped coefficient set
    load_shadow(2000, 20);
    pulse_swap();
    impulse_run("imp");

    // Writes beyond the last coefficient must not disturb either bank
    for (int a = 95; a < 128; a++) begin
      bus_if.coef_we    = 1'b1;
      bus_if.coef_addr  = 7'(a);
      bus_if.coef_wdata = -18'sd5000;
      tick();
    end
    bus_if.coef_we = 1'b0;
    pulse_swap();
    impulse_run("oor");

    // Reset with samples in flight
    load_shadow(1, 0);
    pulse_swap();
    bus_if.in         = 18'sd65536;
    bus_if.sam_clk_en = 1'b1;
    repeat (12) tick();
    check("prerst_valid", longint'(bus_if.out_valid), 1);
    check("prerst_out", longint'(bus_if.out), 2);
    #2 reset = 1'b1;
    #1;
    check("midrst_out", longint'(bus_if.out), 0);
    check("midrst_valid", longint'(bus_if.out_valid), 0);
    bus_if.sam_clk_en = 1'b0;
    #1 reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus_if.out_valid) nv++;
    end
    check("rst_flush_valids", nv, 0);
    bus_if.in         = 18'sd1000;
    bus_if.sam_clk_en = 1'b1;
    tick();
    bus_if.sam_clk_en = 1'b0;
    nv = 0;
    for (int e = 1; e < LAT; e++) begin
      tick();
      if (bus_if.out_valid) nv++;
    end
    check("rst_early_valids", nv, 0);
    tick();
    check("rst_first_valid", longint'(bus_if.out_valid), 1);
    tick();
    check("rst_valid_pulse", longint'(bus_if.out_valid), 0);

    // Back-to-back strobes, unit coefficients, full-scale input
    load_shadow(1, 0);
    pulse_swap();
    bus_if.in         = 18'sd131071;
    bus_if.sam_clk_en = 1'b1;
    repeat (200) tick();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b2b_valid%0d", i), longint'(bus_if.out_valid), 1);
      check($sformatf("b2b_out%0d", i), longint'(bus_if.out), 189);
      tick();
    end
    bus_if.sam_clk_en = 1'b0;

    // Bank swap with a simultaneous shadow write
    load_shadow(2, 0);
    pulse_swap();
    load_shadow(4, 0);
    bus_if.in         = 18'sd65536;
    bus_if.sam_clk_en = 1'b1;
    repeat (200) tick();
    check("swap_before_out", longint'(bus_if.out), 189);
    check("swap_before_valid", longint'(bus_if.out_valid), 1);
    bus_if.coef_swap  = 1'b1;
    bus_if.coef_we    = 1'b1;
    bus_if.coef_addr  = 7'd0;
    bus_if.coef_wdata = 18'sd10;
    tick();
    bus_if.coef_swap = 1'b0;
    bus_if.coef_we   = 1'b0;
    old = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_if.out != 18'sd189) break;
      old++;
    end
    check("swap_old_window", old, LAT - 2);
    check("swap_first_new", longint'(bus_if.out), 378);
    repeat (10) tick();
    check("swap_after_out", longint'(bus_if.out), 378);
    pulse_swap();
    repeat (20) tick();
    check("swap_shadow0_new", longint'(bus_if.out), 384);

    // Full-scale coefficients and input overflow the output width
    load_shadow(131071, 0);
    pulse_swap();
    bus_if.in = 18'sd131071;
    repeat (220) tick();
    check("sat_out", longint'(bus_if.out), SAT_EXP);
    check("sat_valid", longint'(bus_if.out_valid), 1);
    bus_if.sam_clk_en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
